if_fetch_stage: RTL and testbench

//  MIPS instruction-fetch stage: owns the PC register, drives single-outstanding

---
 rtl/if_fetch_stage_if.sv | 10 +
 rtl/if_fetch_stage.sv | 162 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction-memory request/response bus between fetch and imem
interface if_fetch_stage_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS fetch stage: PC, single-outstanding imem requests, IF/ID register
// REQ waits for ack, HOLD parks one word while decode stalls, FLUSH drains a redirected request.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   if_fetch_stage_if.master  imem,
   input  logic              id_stall,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              if_id_valid,
   output logic [31:0]       if_id_instr,
   output logic [31:0]       if_id_pc4
);

   localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_HOLD  = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        req_q, req_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] target_q, target_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [31:0] hold_pc4_q, hold_pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;

   logic        fire;
   logic [31:0] pc_plus4;
   logic [31:0] redir_pc;

   assign fire     = req_q && imem.ack;
   assign pc_plus4 = pc_q + 32'd4;
   assign redir_pc = {redirect_pc[31:2], 2'b00};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC_AL;
         req_q        <= 1'b0;
         addr_q       <= RESET_PC_AL;
         target_q     <= 32'd0;
         hold_instr_q <= 32'd0;
         hold_pc4_q   <= 32'd0;
         valid_q      <= 1'b0;
         instr_q      <= 32'd0;
         pc4_q        <= 32'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_q        <= req_d;
         addr_q       <= addr_d;
         target_q     <= target_d;
         hold_instr_q <= hold_instr_d;
         hold_pc4_q   <= hold_pc4_d;
         valid_q      <= valid_d;
         instr_q      <= instr_d;
         pc4_q        <= pc4_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_d        = req_q;
      addr_d       = addr_q;
      target_d     = target_q;
      hold_instr_d = hold_instr_q;
      hold_pc4_d   = hold_pc4_q;
      valid_d      = valid_q;
      instr_d      = instr_q;
      pc4_d        = pc4_q;

      case (state_q)
         S_REQ: begin
            if (redirect_valid) begin
               valid_d = 1'b0;
               if (fire || !req_q) begin
                  pc_d   = redir_pc;
                  req_d  = 1'b1;
                  addr_d = redir_pc;
               end else begin
                  // Request still in flight: keep it on the bus until it drains.
                  state_d  = S_FLUSH;
                  target_d = redir_pc;
               end
            end else if (!req_q) begin
               req_d  = 1'b1;
               addr_d = pc_q;
            end else if (fire) begin
               pc_d = pc_plus4;
               if (!id_stall) begin
                  valid_d = 1'b1;
                  instr_d = imem.rdata;
                  pc4_d   = pc_plus4;
                  addr_d  = pc_plus4;
               end else begin
                  hold_instr_d = imem.rdata;
                  hold_pc4_d   = pc_plus4;
                  req_d        = 1'b0;
                  state_d      = S_HOLD;
               end
            end else if (!id_stall) begin
               valid_d = 1'b0;
            end
         end

         S_HOLD: begin
            if (redirect_valid) begin
               valid_d = 1'b0;
               pc_d    = redir_pc;
               req_d   = 1'b1;
               addr_d  = redir_pc;
               state_d = S_REQ;
            end else if (!id_stall) begin
               valid_d = 1'b1;
               instr_d = hold_instr_q;
               pc4_d   = hold_pc4_q;
               req_d   = 1'b1;
               addr_d  = pc_q;
               state_d = S_REQ;
            end
         end

         S_FLUSH: begin
            valid_d = 1'b0;
            if (redirect_valid) begin
               if (fire) begin
                  pc_d    = redir_pc;
                  addr_d  = redir_pc;
                  state_d = S_REQ;
               end else begin
                  target_d = redir_pc;
               end
            end else if (fire) begin
               pc_d    = target_q;
               addr_d  = target_q;
               state_d = S_REQ;
            end
         end

         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   assign imem.req    = req_q;
   assign imem.addr   = addr_q;
   assign if_id_valid = valid_q;
   assign if_id_instr = instr_q;
   assign if_id_pc4   = pc4_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - scoreboard bench for if_fetch_stage with a wait-stated memory model
module tb_if_fetch_stage;
   localparam logic [31:0] RPC = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;

   if_fetch_stage_if imem ();

   if_fetch_stage #(.RESET_PC(RPC)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem           (imem),
      .id_stall       (id_stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_id_valid    (if_id_valid),
      .if_id_instr    (if_id_instr),
      .if_id_pc4      (if_id_pc4)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          fails = 0;
   int          consumed = 0;
   logic [31:0] seg_q[$];
   logic [31:0] next_pc = RPC;
   int          wait_mode = 0;
   bit          pending = 0;
   int          wait_left = 0;
   bit          fresh = 0;
   bit          prev_wait = 0;
   logic [31:0] prev_addr = 32'd0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'hBFC0_0000) return 32'h2008_0005;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
      end
   endtask

   // Memory: each new request picks its wait count; ack is asserted in the data cycle.
   task automatic mem_update();
      fresh = 0;
      if (reset) begin
         imem.ack  = 1'b0;
         pending   = 0;
         prev_wait = 0;
         return;
      end
      if (prev_wait && imem.req) check32("addr_stable", imem.addr, prev_addr);
      if (imem.req) begin
         check32("addr_align", {30'd0, imem.addr[1:0]}, 32'd0);
         if (!pending) begin
            pending   = 1;
            fresh     = 1;
            wait_left = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
         end
         if (wait_left == 0) begin
            imem.ack   = 1'b1;
            imem.rdata = mem_word(imem.addr);
            pending    = 0;
         end else begin
            imem.ack   = 1'b0;
            imem.rdata = $urandom;
            wait_left--;
         end
      end else begin
         imem.ack = 1'b0;
         pending  = 0;
      end
      prev_wait = imem.req && !imem.ack;
      prev_addr = imem.addr;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      mem_update();
   endtask

   task automatic do_redirect(input logic [31:0] t);
      redirect_valid = 1'b1;
      redirect_pc    = t;
      seg_q.push_back({t[31:2], 2'b00});
   endtask

   // Monitor: decode consumes IF/ID when valid and not stalled; stream must be sequential per segment.
   always @(negedge clk) begin
      if (reset) begin
         next_pc = RPC;
         seg_q.delete();
      end else begin
         if (if_id_valid && !id_stall) begin
            check32("instr", if_id_instr, mem_word(next_pc));
            check32("pc4", if_id_pc4, next_pc + 32'd4);
            next_pc = next_pc + 32'd4;
            consumed++;
         end
         if (redirect_valid) begin
            if (seg_q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL seg_queue actual=empty required=entry");
            end else begin
               next_pc = seg_q.pop_front();
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int n;
      int c0;
      logic [31:0] snap;
      logic [31:0] old;

      reset = 1'b1;
      id_stall = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'd0;
      imem.ack = 1'b0;
      imem.rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check32("rst_req", {31'd0, imem.req}, 32'd0);
      check32("rst_addr", imem.addr, RPC);
      check32("rst_valid", {31'd0, if_id_valid}, 32'd0);
      check32("rst_instr", if_id_instr, 32'd0);
      check32("rst_pc4", if_id_pc4, 32'd0);

      // First fetch with zero-wait memory
      reset = 1'b0;
      wait_mode = 0;
      cycle();
      check32("t1_req", {31'd0, imem.req}, 32'd1);
      check32("t1_addr", imem.addr, RPC);
      cycle();
      check32("t1_valid", {31'd0, if_id_valid}, 32'd1);
      check32("t1_instr", if_id_instr, 32'h2008_0005);
      check32("t1_pc4", if_id_pc4, 32'hBFC0_0004);
      check32("t1_addr2", imem.addr, 32'hBFC0_0004);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (if_id_valid) cnt++;
      end
      check_range("zero_wait_rate", cnt, 20, 20);

      // Three wait states: one instruction every four cycles
      wait_mode = 3;
      repeat (8) cycle();
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (if_id_valid) cnt++;
      end
      check_range("wait3_rate", cnt, 9, 11);

      // Stall at ack parks the word in HOLD with the bus idle
      wait_mode = 0;
      repeat (4) cycle();
      snap = if_id_instr;
      id_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check32("hold_req", {31'd0, imem.req}, 32'd0);
         check32("hold_valid", {31'd0, if_id_valid}, 32'd1);
         check32("hold_instr", if_id_instr, snap);
      end
      id_stall = 1'b0;
      wait_mode = -1;
      c0 = consumed;
      n = 0;
      while (consumed < c0 + 20 && n < 400) begin
         id_stall = ($urandom_range(0, 9) < 4);
         cycle();
         n++;
      end
      check_range("stream20", consumed - c0, 20, 1000);
      id_stall = 1'b0;

      // Redirect while a request is pending: returned data dropped
      wait_mode = 2;
      n = 0;
      cycle();
      while (!fresh && n < 20) begin
         cycle();
         n++;
      end
      check_range("t4_fresh_found", n, 0, 19);
      old = imem.addr;
      do_redirect(32'h0040_0100);
      cycle();
      check32("t4_valid", {31'd0, if_id_valid}, 32'd0);
      check32("t4_req", {31'd0, imem.req}, 32'd1);
      check32("t4_addr_held", imem.addr, old);
      n = 0;
      while (imem.addr == old && n < 10) begin
         cycle();
         check32("t4_flush_valid", {31'd0, if_id_valid}, 32'd0);
         n++;
      end
      check32("t4_new_addr", imem.addr, 32'h0040_0100);

      // Redirect and stall in the same cycle, unaligned target
      wait_mode = 0;
      repeat (3) cycle();
      id_stall = 1'b1;
      do_redirect(32'h0040_0103);
      cycle();
      check32("t5_valid", {31'd0, if_id_valid}, 32'd0);
      check32("t5_req", {31'd0, imem.req}, 32'd1);
      check32("t5_addr", imem.addr, 32'h0040_0100);
      id_stall = 1'b0;
      repeat (3) cycle();

      // PC wrap at the top of the address space
      do_redirect(32'hFFFF_FFFC);
      cycle();
      check32("t6_addr_top", imem.addr, 32'hFFFF_FFFC);
      cycle();
      check32("t6_valid", {31'd0, if_id_valid}, 32'd1);
      check32("t6_pc4", if_id_pc4, 32'h0000_0000);
      check32("t6_addr_wrap", imem.addr, 32'h0000_0000);

      // Reset in the middle of a wait-stated request
      wait_mode = 3;
      n = 0;
      cycle();
      while (!fresh && n < 20) begin
         cycle();
         n++;
      end
      cycle();
      check32("t6_midwait_req", {31'd0, imem.req}, 32'd1);
      reset = 1'b1;
      #1;
      check32("t6_rst_req", {31'd0, imem.req}, 32'd0);
      check32("t6_rst_valid", {31'd0, if_id_valid}, 32'd0);
      check32("t6_rst_addr", imem.addr, RPC);
      mem_update();
      repeat (2) cycle();
      reset = 1'b0;
      wait_mode = 0;
      cycle();
      check32("t6_refetch_req", {31'd0, imem.req}, 32'd1);
      check32("t6_refetch_addr", imem.addr, RPC);
      cycle();
      check32("t6_refetch_instr", if_id_instr, 32'h2008_0005);

      // Randomized traffic: waits, stalls, redirects (some near the wrap point)
      wait_mode = -1;
      c0 = consumed;
      for (int i = 0; i < 1500; i++) begin
         id_stall = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 99) < 3) begin
            if ($urandom_range(0, 3) == 0) do_redirect(32'hFFFF_FFE0 | ($urandom & 32'h1F));
            else do_redirect($urandom);
         end
         cycle();
      end
      id_stall = 1'b0;
      repeat (20) cycle();
      check_range("random_progress", consumed - c0, 200, 100000);
      check_range("seg_q_drained", seg_q.size(), 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
